int_priority_ctrl: RTL
======================

Name: int_priority_ctrl

Overview:
- Front-end scheduler for the interrupt unit. Arbitrates three external interrupt request lines with fixed priority (src3 > src2 > src1).
- Tracks pending and in-service levels to support nesting.
- Drives the interrupt unit's 2-bit cause code and one-cycle break pulse.
- Sits between the board-level request inputs and the interrupt unit; consumes the CPU's eret and interrupt-enable status.

Parameters:
- CNT_W, 8, width of each per-source accepted-interrupt counter (display/debug).
- HOLD_CYC, 2, cycles the arbiter stays blocked after issuing a break, so the pipeline flush completes before the next decision (legal range 1..7).

Ports:
- in_CLK  input  1  system clock; all state changes on rising edge.
- in_RST  input  1  reset; asynchronous, active-high.
- in_req  input  3  raw request lines; bit i = source i+1; level, may be held.
- in_IE  input  1  global interrupt enable from the interrupt unit (1 = breaks allowed).
- in_eret  input  1  eret executing this cycle (one-cycle pulse from the decoder).
- in_stall  input  1  pipeline cannot take a break this cycle (e.g. branch in EX); issue is deferred.
- out_code  output  2  cause code to the interrupt unit; 0 = none, 1..3 = source.
- out_BK  output  1  one-cycle break request.
- out_pending  output  3  pending mask.
- out_inservice  output  3  in-service mask.
- out_cnt1, out_cnt2, out_cnt3  output  CNT_W each  accepted-break counts per source.

Behaviour:
- Reset (async, any time, including mid-HOLD): pending=0, inservice=0, out_code=0, out_BK=0, counters=0, state=IDLE, previous-request register=0.
- Edge detect: pending[i] is set on a rising edge of in_req[i] (registered previous value). A held level sets pending only once.
- cur_lvl = index of the highest set inservice bit (0 if none). top_p = index of the highest set pending bit (0 if none).
- State IDLE:
  - Issue when top_p > cur_lvl, in_IE=1, in_stall=0 and in_eret=0.
  - Next cycle: out_BK=1, out_code=top_p, pending[top_p] cleared, inservice[top_p] set, out_cnt<top_p> incremented (wraps at 2^CNT_W), state→HOLD.
  - Latency: request edge sampled at cycle N → earliest out_BK at N+2.
- State HOLD:
  - out_BK=0 and out_code holds its value.
  - Counter runs HOLD_CYC cycles, then state→IDLE.
  - No issue decisions are made in HOLD; edges are still captured into pending.
- eret, in any state:
  - Clears the highest set inservice bit. If none is set, no effect.
  - out_code is set to the new cur_lvl, so the interrupt unit restores the interrupted level.
  - An issue is suppressed in the same cycle; it is re-evaluated the next cycle.
- Simultaneous rising edge and issue of the same source: the new edge is dropped, since the request is being serviced.
- Equal or lower priority than cur_lvl stays pending until eret lowers cur_lvl.
- in_IE=0 blocks issue only; pending still accumulates.
- out_code=0 whenever inservice=0 and not in HOLD.

Test Plan:
- Reset mid-HOLD: raise in_req=001 → out_BK pulse with code 1; assert in_RST during HOLD → all outputs 0 immediately; state=IDLE after release.
- Single request: in_req 000→001 at cycle 5 → out_BK=1 and out_code=1 at cycle 7; inservice=001; cnt1=1; holding in_req high produces no second break.
- Nesting: src1 in service, then edge on src3 → break code 3, inservice=101. Then eret → inservice=001 and out_code=1. Second eret → inservice=000 and out_code=0.
- Blocking: src3 in service, edge on src2 → no break, pending=010. After eret → break code 2 issued one cycle after the eret cycle, once not in HOLD.
- Simultaneous edges on all three lines → code 3, then after eret code 2, then after eret code 1; counters are 1,1,1.
- in_stall=1 or in_IE=0 for 10 cycles with pending=010 → out_BK stays 0. Deassert → break issues within 1 cycle. Counter wrap with CNT_W=2: 4 src1 breaks → cnt1=0.

Source files
------------

// File: rtl/int_priority_ctrl_if.sv
// Bundles the request inputs and scheduler outputs of int_priority_ctrl.
// master = board/CPU side that drives requests and status; slave = the controller.
interface int_priority_ctrl_if #(
    parameter int CNT_W = 8
);
    logic [2:0]       in_req;
    logic             in_IE;
    logic             in_eret;
    logic             in_stall;
    logic [1:0]       out_code;
    logic             out_BK;
    logic [2:0]       out_pending;
    logic [2:0]       out_inservice;
    logic [CNT_W-1:0] out_cnt1;
    logic [CNT_W-1:0] out_cnt2;
    logic [CNT_W-1:0] out_cnt3;

    modport master (
        output in_req, in_IE, in_eret, in_stall,
        input  out_code, out_BK, out_pending, out_inservice,
        input  out_cnt1, out_cnt2, out_cnt3
    );

    modport slave (
        input  in_req, in_IE, in_eret, in_stall,
        output out_code, out_BK, out_pending, out_inservice,
        output out_cnt1, out_cnt2, out_cnt3
    );
endinterface

// File: rtl/int_priority_ctrl.sv
// Fixed-priority interrupt front end: captures request edges into a pending
// mask, issues one-cycle breaks for sources above the current in-service
// level, tracks nesting and restores the interrupted level on eret.
module int_priority_ctrl #(
    parameter int CNT_W    = 8,
    parameter int HOLD_CYC = 2
) (
    input  logic                in_CLK,
    input  logic                in_RST,
    int_priority_ctrl_if.slave  bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    localparam logic [2:0] HOLD_LAST = 3'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       state_reg;
    logic [2:0]       hold_cnt_reg;
    logic [2:0]       prev_req_reg;
    logic [2:0]       pending_reg;
    logic [2:0]       inservice_reg;
    logic [1:0]       code_reg;
    logic             bk_reg;
    logic [CNT_W-1:0] cnt_reg [1:3];

    logic [2:0] edge_det;
    logic [1:0] cur_lvl;
    logic [1:0] top_p;
    logic       issue;
    logic [2:0] issue_mask;
    logic [2:0] eret_mask;
    logic [2:0] inservice_after_eret;
    logic [2:0] pending_next;
    logic [2:0] inservice_next;
    logic [1:0] code_next;

    // Index (1..3) of the highest set bit, 0 when the mask is empty.
    function automatic logic [1:0] highest(input logic [2:0] m);
        if (m[2])      return 2'd3;
        else if (m[1]) return 2'd2;
        else if (m[0]) return 2'd1;
        else           return 2'd0;
    endfunction

    // One-hot mask for a source level; level 0 selects nothing.
    function automatic logic [2:0] onehot(input logic [1:0] lvl);
        case (lvl)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Issue decision and next-state values for the masks and cause code.
    always_comb begin
        edge_det             = bus.in_req & ~prev_req_reg;
        cur_lvl              = highest(inservice_reg);
        top_p                = highest(pending_reg);
        issue                = (state_reg == IDLE) && (top_p > cur_lvl) &&
                               bus.in_IE && !bus.in_stall && !bus.in_eret;
        issue_mask           = issue ? onehot(top_p) : 3'b000;
        eret_mask            = bus.in_eret ? onehot(cur_lvl) : 3'b000;
        inservice_after_eret = inservice_reg & ~eret_mask;
        // An edge arriving on the source being issued is absorbed by the issue.
        pending_next         = (pending_reg | edge_det) & ~issue_mask;
        inservice_next       = inservice_after_eret | issue_mask;
        code_next            = code_reg;
        if (issue)
            code_next = top_p;
        else if (bus.in_eret)
            code_next = highest(inservice_after_eret);
    end

    // Scheduler state: a break blocks further decisions for HOLD_CYC cycles.
    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= 3'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (issue) begin
                        state_reg    <= HOLD;
                        hold_cnt_reg <= 3'd0;
                    end
                end
                default: begin
                    if (hold_cnt_reg >= HOLD_LAST) begin
                        state_reg    <= IDLE;
                        hold_cnt_reg <= 3'd0;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 3'd1;
                    end
                end
            endcase
        end
    end

    // Request edge history plus pending and in-service masks.
    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            prev_req_reg  <= 3'b000;
            pending_reg   <= 3'b000;
            inservice_reg <= 3'b000;
        end else begin
            prev_req_reg  <= bus.in_req;
            pending_reg   <= pending_next;
            inservice_reg <= inservice_next;
        end
    end

    // Cause code and single-cycle break pulse toward the interrupt unit.
    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            code_reg <= 2'd0;
            bk_reg   <= 1'b0;
        end else begin
            code_reg <= code_next;
            bk_reg   <= issue;
        end
    end

    // Per-source accepted-break counters, wrapping at 2^CNT_W.
    generate
        for (genvar gi = 1; gi <= 3; gi++) begin : g_cnt
            // Count each break issued for source gi.
            always_ff @(posedge in_CLK or posedge in_RST) begin
                if (in_RST)
                    cnt_reg[gi] <= '0;
                else if (issue_mask[gi-1])
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_ONE;
            end
        end
    endgenerate

    assign bus.out_code      = code_reg;
    assign bus.out_BK        = bk_reg;
    assign bus.out_pending   = pending_reg;
    assign bus.out_inservice = inservice_reg;
    assign bus.out_cnt1      = cnt_reg[1];
    assign bus.out_cnt2      = cnt_reg[2];
    assign bus.out_cnt3      = cnt_reg[3];

endmodule
